fetch_ifid_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register.
- Sits directly upstream of the data-forwarding/hazard unit and produces the instrIFID word that unit decodes.
- Consumes the hazard unit's stall and calc_branch results to hold, redirect and flush.
- Talks to instruction memory over a req/ack handshake with variable latency and holds one skid entry so no fetched word is lost.

---
 rtl/fetch_ifid_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: req/ack instruction-memory handshake, one-entry skid and IF/ID register.
// Optional stall/redirect counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        calc_branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrIFID,
    output logic [31:0] pcIFID,
    output logic        validIFID,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] old_addr_reg, old_addr_next;
    logic [31:0] skid_reg, skid_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_ifid_reg, pc_ifid_next;
    logic        valid_reg, valid_next;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        bubble;

    assign redirect = calc_branch & branch_taken & ~stall;
    assign target   = branch_target & ~32'd3;
    assign pc_plus4 = pc_reg + 32'd4;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (redirect) begin
                    state_next = imem_ack ? REQ : DISCARD;
                end else if (imem_ack && stall) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_next = REQ;
                end
            end
            DISCARD: begin
                // The wrong-path word is dropped whenever it finally arrives.
                if (imem_ack) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: a discarded request keeps presenting its original address until acked.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_reg;
        case (state_reg)
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_reg;
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = old_addr_reg;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = pc_reg;
            end
        endcase
    end

    // Datapath next values: redirect beats stall beats normal advance.
    always_comb begin
        pc_next       = pc_reg;
        old_addr_next = old_addr_reg;
        skid_next     = skid_reg;
        instr_next    = instr_reg;
        pc_ifid_next  = pc_ifid_reg;
        valid_next    = valid_reg;
        bubble        = 1'b0;

        if (redirect) begin
            pc_next   = target;
            skid_next = NOP_INSTR;
            bubble    = 1'b1;
            if (state_reg == REQ && !imem_ack) begin
                old_addr_next = pc_reg;
            end
        end else begin
            case (state_reg)
                REQ: begin
                    if (imem_ack) begin
                        pc_next = pc_plus4;
                        if (stall) begin
                            skid_next = imem_rdata;
                        end else begin
                            instr_next   = imem_rdata;
                            pc_ifid_next = pc_plus4;
                            valid_next   = 1'b1;
                        end
                    end else if (!stall) begin
                        bubble = 1'b1;
                    end
                end
                HOLD: begin
                    // pc already advanced past the skid word, so it is that word's PC+4.
                    if (!stall) begin
                        instr_next   = skid_reg;
                        pc_ifid_next = pc_reg;
                        valid_next   = 1'b1;
                        skid_next    = NOP_INSTR;
                    end
                end
                default: begin
                    if (!stall) begin
                        bubble = 1'b1;
                    end
                end
            endcase
        end

        // A cycle that delivers no word while decode advances must not replay the old one.
        if (bubble) begin
            instr_next   = NOP_INSTR;
            pc_ifid_next = 32'd0;
            valid_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            old_addr_reg <= RESET_PC;
            skid_reg     <= NOP_INSTR;
            instr_reg    <= NOP_INSTR;
            pc_ifid_reg  <= 32'd0;
            valid_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            old_addr_reg <= old_addr_next;
            skid_reg     <= skid_next;
            instr_reg    <= instr_next;
            pc_ifid_reg  <= pc_ifid_next;
            valid_reg    <= valid_next;
        end
    end

    assign instrIFID = instr_reg;
    assign pcIFID    = pc_ifid_reg;
    assign validIFID = valid_reg;

`ifdef FETCH_PERF_CNT_EN
    // Index 0 counts stalled cycles, index 1 counts accepted redirects; both saturate.
    logic [1:0] cnt_inc;
    assign cnt_inc = {redirect, stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [15:0] cnt_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= 16'd0;
            end else if (cnt_inc[gi] && cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign stall_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt = g_cnt[1].cnt_reg;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule
